ldconv_seq: RTL and testbench

Multi-cycle load data converter for the RV32I datapath; the read-side counterpart of the store data converter. It accepts a load request (IR plus effective byte address) and fetches one or two aligned words from data memory over a valid handshake. It then selects, combines and sign- or zero-extends the addressed bytes into a 32-bit register-file write value. It sits between the address adder and the register-file write-back mux, and splits misaligned LH/LW accesses into two word reads.

---
 rtl/ldconv_seq_pkg.sv | 40 ++++
 rtl/ldconv_seq_ldext.sv | 38 +++
 rtl/ldconv_seq.sv | 129 ++++++++++++
 tb/tb_ldconv_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ldconv_seq_pkg.sv
// Shared load/store defines for the RV32I load and store data converters.
package ldconv_seq_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // True for the five load encodings this converter supports.
    function automatic logic load_legal(input logic [6:0] opc, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (opc == OPC_LOAD) begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Access size in bytes for a legal load funct3.
    function automatic logic [2:0] load_size(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3)
            F3_LH, F3_LHU: sz = 3'd2;
            F3_LW:         sz = 3'd4;
            default:       sz = 3'd1;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ldconv_seq_ldext.sv
// Load lane extraction: shifts the two-word window down to the addressed
// byte and sign- or zero-extends according to funct3.
module ldext
    import ldconv_seq_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rd_data
);

    logic [31:0] lane;

    // Byte offset selects the starting lane; word1 supplies the spill-over bytes.
    assign lane = 32'(words >> {offset, 3'b000});

    function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
        return 32'(b);
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
        return 32'(h);
    endfunction

    // Width and extension selection; unsupported funct3 yields zero.
    always_comb begin
        rd_data = 32'h0;
        case (funct3)
            F3_LB:   rd_data = sext8(lane[7:0]);
            F3_LH:   rd_data = sext16(lane[15:0]);
            F3_LW:   rd_data = lane;
            F3_LBU:  rd_data = {24'h0, lane[7:0]};
            F3_LHU:  rd_data = {16'h0, lane[15:0]};
            default: rd_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/ldconv_seq.sv
// Multi-cycle RV32I load data converter: fetches one or two aligned words
// over a valid handshake and produces the extended register write value.
module ldconv_seq
    import ldconv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] rd_data,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] word0_q;
    logic [31:0] word1_q;
    logic [31:0] rd_data_q;
    logic        err_q;

    logic [31:0] word0_nxt;
    logic [31:0] word1_nxt;
    logic [31:0] ext_data;
    logic [31:0] word0_addr;
    logic [2:0]  span_end;
    logic        split;
    logic        req_legal;
    logic        unused_ir_bits;

    // Only opcode and funct3 matter to a load; the rest of the IR is ignored.
    assign unused_ir_bits = ^{ir[31:15], ir[11:7]};
    assign req_legal      = load_legal(ir[6:0], ir[14:12]);

    // A split access runs past the end of the first word.
    assign span_end   = {1'b0, addr_q[1:0]} + load_size(funct3_q);
    assign split      = (span_end > 3'd4);
    assign word0_addr = {addr_q[31:2], 2'b00};

    // Words as they will be after this edge, so the result can be registered
    // on the same edge that delivers the last read word.
    assign word0_nxt = (state == RD0 && mem_rvalid) ? mem_rdata : word0_q;
    assign word1_nxt = (state == RD1 && mem_rvalid) ? mem_rdata : word1_q;

    ldext u_ldext (
        .words   ({word1_nxt, word0_nxt}),
        .offset  (addr_q[1:0]),
        .funct3  (funct3_q),
        .rd_data (ext_data)
    );

    // Handshake and memory port decoded purely from state and captured address.
    assign req_ready  = (state == IDLE);
    assign mem_rd_en  = (state == RD0) || (state == RD1);
    assign mem_addr   = (state == RD0) ? word0_addr :
                        (state == RD1) ? word0_addr + 32'd4 : 32'h0;
    assign resp_valid = (state == DONE);
    assign rd_data    = rd_data_q;
    assign err        = err_q;

    // Sequencer: accept, one or two word reads, one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            funct3_q  <= 3'h0;
            addr_q    <= 32'h0;
            word0_q   <= 32'h0;
            word1_q   <= 32'h0;
            rd_data_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= ir[14:12];
                        addr_q   <= addr;
                        word0_q  <= 32'h0;
                        word1_q  <= 32'h0;
                        if (req_legal) begin
                            state <= RD0;
                        end else begin
                            state     <= DONE;
                            err_q     <= 1'b1;
                            rd_data_q <= 32'h0;
                        end
                    end
                end
                RD0: begin
                    if (mem_rvalid) begin
                        word0_q <= word0_nxt;
                        if (split) begin
                            state <= RD1;
                        end else begin
                            state     <= DONE;
                            rd_data_q <= ext_data;
                            err_q     <= 1'b0;
                        end
                    end
                end
                RD1: begin
                    if (mem_rvalid) begin
                        word1_q   <= word1_nxt;
                        state     <= DONE;
                        rd_data_q <= ext_data;
                        err_q     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldconv_seq.sv
// Directed bench for ldconv_seq: table of load vectors plus reset corner cases.
module tb_ldconv_seq;
    import ldconv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] ir;
    logic [31:0] addr;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] rd_data;
    logic        err;

    // Memory model state: two words, a fixed read delay, and override knobs.
    logic [31:0] m_a0, m_d0, m_a1, m_d1;
    int          cur_delay;
    int          wait_cnt;
    logic        hold_rv;
    logic        force_rv;

    int n_vec;
    int n_miss;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] addr;
        int          delay;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
    } vec_t;

    vec_t vecs[13];

    ldconv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ir         (ir),
        .addr       (addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .rd_data    (rd_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign mem_rvalid = force_rv || (mem_rd_en && !hold_rv && (wait_cnt >= cur_delay));
    assign mem_rdata  = (mem_addr == m_a0) ? m_d0 :
                        (mem_addr == m_a1) ? m_d1 : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (!mem_rd_en || mem_rvalid) wait_cnt <= 0;
        else                          wait_cnt <= wait_cnt + 1;
    end

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] opc);
        return {17'h0, f3, 5'd10, opc};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, input logic [31:0] a, input int dly,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] ed, input logic ee,
                                 input int lat, input int nrd);
        vec_t v;
        v.ir = i; v.addr = a; v.delay = dly;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_nrd = nrd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int          lat;
        int          nrd;
        int          nrdcyc;
        logic [31:0] got_d;
        logic        got_e;
        m_a0 = v.a0; m_d0 = v.d0; m_a1 = v.a1; m_d1 = v.d1;
        cur_delay = v.delay;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        ir = v.ir; addr = v.addr; req_valid = 1'b1;
        @(posedge clk);
        lat = 0; nrd = 0; nrdcyc = 0; got_d = 32'h0; got_e = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0; ir = 32'hFFFFFFFF; addr = 32'h5A5A5A5A;
            if (mem_rd_en) begin
                nrdcyc++;
                check({tag, " mem_addr"}, mem_addr, (nrd == 0) ? v.a0 : v.a1);
                if (mem_rvalid) nrd++;
            end
            if (resp_valid) begin
                lat = k; got_d = rd_data; got_e = err;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " rd_data"}, got_d, v.exp_data);
        check({tag, " err"}, 32'(got_e), 32'(v.exp_err));
        check({tag, " reads"}, 32'(nrd), 32'(v.exp_nrd));
        check({tag, " rd_en cycles"}, 32'(nrdcyc), v.exp_err ? 32'd0 : 32'(v.exp_lat - 1));
        @(negedge clk);
        check({tag, " pulse end"}, 32'(resp_valid), 32'd0);
        check({tag, " ready again"}, 32'(req_ready), 32'd1);
        check({tag, " rd_data held"}, rd_data, got_d);
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1; req_valid = 1'b0; ir = 32'h0; addr = 32'h0;
        hold_rv = 1'b0; force_rv = 1'b0; cur_delay = 0;
        m_a0 = 32'h0; m_d0 = 32'h0; m_a1 = 32'h4; m_d1 = 32'h0;

        //           ir                      addr          dly a0            d0            a1            d1            exp_data      err lat nrd
        vecs[0]  = mkv(mk_ir(F3_LB,  OPC_LOAD),  32'h00001001, 0, 32'h00001000, 32'h12AB80FF, 32'h00001004, 32'h0,        32'hFFFFFF80, 0, 2, 1);
        vecs[1]  = mkv(mk_ir(F3_LBU, OPC_LOAD),  32'h00001001, 0, 32'h00001000, 32'h12AB80FF, 32'h00001004, 32'h0,        32'h00000080, 0, 2, 1);
        vecs[2]  = mkv(mk_ir(F3_LH,  OPC_LOAD),  32'h00002003, 0, 32'h00002000, 32'h11223344, 32'h00002004, 32'h55667788, 32'hFFFF8811, 0, 3, 2);
        vecs[3]  = mkv(mk_ir(F3_LW,  OPC_LOAD),  32'hFFFFFFFE, 0, 32'hFFFFFFFC, 32'hDDCCBBAA, 32'h00000000, 32'h44332211, 32'h2211DDCC, 0, 3, 2);
        vecs[4]  = mkv(mk_ir(F3_LW,  OPC_LOAD),  32'h00000100, 3, 32'h00000100, 32'hCAFEF00D, 32'h00000104, 32'h0,        32'hCAFEF00D, 0, 5, 1);
        vecs[5]  = mkv(mk_ir(3'b011, OPC_LOAD),  32'h00000100, 0, 32'h00000100, 32'hCAFEF00D, 32'h00000104, 32'h0,        32'h00000000, 1, 1, 0);
        vecs[6]  = mkv(mk_ir(F3_LW,  OPC_STORE), 32'h00000100, 0, 32'h00000100, 32'hCAFEF00D, 32'h00000104, 32'h0,        32'h00000000, 1, 1, 0);
        vecs[7]  = mkv(mk_ir(F3_LHU, OPC_LOAD),  32'h00002003, 0, 32'h00002000, 32'h11223344, 32'h00002004, 32'h55667788, 32'h00008811, 0, 3, 2);
        vecs[8]  = mkv(mk_ir(F3_LH,  OPC_LOAD),  32'h00002002, 0, 32'h00002000, 32'h11223344, 32'h00002004, 32'h55667788, 32'h00001122, 0, 2, 1);
        vecs[9]  = mkv(mk_ir(F3_LW,  OPC_LOAD),  32'h00002001, 1, 32'h00002000, 32'h11223344, 32'h00002004, 32'h55667788, 32'h88112233, 0, 5, 2);
        vecs[10] = mkv(mk_ir(F3_LB,  OPC_LOAD),  32'h00001003, 0, 32'h00001000, 32'h12AB80FF, 32'h00001004, 32'h0,        32'h00000012, 0, 2, 1);
        vecs[11] = mkv(mk_ir(F3_LH,  OPC_LOAD),  32'h00001000, 0, 32'h00001000, 32'h12AB80FF, 32'h00001004, 32'h0,        32'hFFFF80FF, 0, 2, 1);
        vecs[12] = mkv(mk_ir(3'b110, OPC_LOAD),  32'h00001000, 0, 32'h00001000, 32'h12AB80FF, 32'h00001004, 32'h0,        32'h00000000, 1, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset rd_data", rd_data, 32'h0);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Produce a nonzero result so the reset clearing rd_data is visible.
        run_req(vecs[0], "pre-reset");

        // Reset while stalled in RD0, then a stray read-valid arrives.
        hold_rv = 1'b1;
        m_a0 = 32'h00000100; m_d0 = 32'hCAFEF00D;
        @(negedge clk);
        ir = mk_ir(F3_LW, OPC_LOAD); addr = 32'h00000100; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst rd_en before", 32'(mem_rd_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst async rd_en", 32'(mem_rd_en), 32'd0);
        check("midrst async ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; hold_rv = 1'b0; force_rv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst no resp", 32'(resp_valid), 32'd0);
            check("midrst ready", 32'(req_ready), 32'd1);
            check("midrst no rd_en", 32'(mem_rd_en), 32'd0);
        end
        check("midrst rd_data cleared", rd_data, 32'h0);
        force_rv = 1'b0;
        run_req(vecs[4], "post-reset LW");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
